// File: rtl/dt_res_init.sv
// Unpacks a 128x128 binary image (1024 x 16-bit ROM words) into one byte per pixel in res_RAM.
// Latency: one FETCH cycle after start, then 16384 back-to-back write cycles, then a one-cycle done pulse.
// No backpressure: ROM data is taken one edge after sti_rd, and a RAM write is issued every WRITE cycle.
module dt_res_init #(
  parameter logic [7:0] FG_VAL      = 8'h01,
  parameter logic [7:0] BG_VAL      = 8'h00,
  parameter bit         BORDER_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sti_rd,
  output logic [9:0]  sti_addr,
  input  logic [15:0] sti_di,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  word;
  logic [3:0]  cnt;
  logic [15:0] shreg;       // current ROM word; the pixel being written is always bit 15
  logic [13:0] addr_hold;   // last written address, presented while not writing
  logic [7:0]  do_hold;     // last written data, presented while not writing

  logic        last_pix;
  logic        last_word;
  logic        prefetch;
  logic [6:0]  row;
  logic [6:0]  col;
  logic        border;
  logic [7:0]  pix_do;

  assign last_pix  = (cnt == 4'hF);
  assign last_word = (word == 10'd1023);
  // The next word is read during the last pixel of the current one so writes never stall.
  assign prefetch  = (state == WRITE) && last_pix && !last_word;

  // Pixel value: border override first, then the ROM bit selects foreground/background.
  assign row    = word[9:3];
  assign col    = {word[2:0], cnt};
  assign border = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
  assign pix_do = (BORDER_ZERO && border) ? BG_VAL : (shreg[15] ? FG_VAL : BG_VAL);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so a held start re-arms only from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = WRITE;
      WRITE:   if (last_pix && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registers only; address/data hold their last written values outside WRITE.
  always_comb begin
    busy     = (state == FETCH) || (state == WRITE);
    done     = (state == DONE);
    res_wr   = (state == WRITE);
    sti_rd   = (state == FETCH) || prefetch;
    sti_addr = prefetch ? (word + 10'd1) : 10'd0;
    res_addr = (state == WRITE) ? {word, cnt} : addr_hold;
    res_do   = (state == WRITE) ? pix_do : do_hold;
  end

  // Datapath: load a word on each ROM read, otherwise shift the next pixel into bit 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word      <= 10'd0;
      cnt       <= 4'd0;
      shreg     <= 16'd0;
      addr_hold <= 14'd0;
      do_hold   <= 8'd0;
    end else begin
      case (state)
        FETCH: begin
          shreg <= sti_di;
          word  <= 10'd0;
          cnt   <= 4'd0;
        end
        WRITE: begin
          cnt       <= cnt + 4'd1;
          addr_hold <= {word, cnt};
          do_hold   <= pix_do;
          if (prefetch) begin
            shreg <= sti_di;
            word  <= word + 10'd1;
          end else begin
            shreg <= {shreg[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_res_init.sv
// Bench for dt_res_init: three instances (default values, no border override, FF/10 with border)
// share one ROM model and are compared against a reference RAM image built from the pixel rules.
module tb_dt_res_init;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  logic [15:0] rom [0:1023];

  logic        busy_a, done_a, sti_rd_a, res_wr_a;
  logic [9:0]  sti_addr_a;
  logic [13:0] res_addr_a;
  logic [7:0]  res_do_a;
  logic [15:0] sti_di_a;
  logic        busy_b, done_b, sti_rd_b, res_wr_b;
  logic [9:0]  sti_addr_b;
  logic [13:0] res_addr_b;
  logic [7:0]  res_do_b;
  logic [15:0] sti_di_b;
  logic        busy_c, done_c, sti_rd_c, res_wr_c;
  logic [9:0]  sti_addr_c;
  logic [13:0] res_addr_c;
  logic [7:0]  res_do_c;
  logic [15:0] sti_di_c;

  // ROM returns junk when not strobed, so data taken at the wrong edge corrupts the image.
  assign sti_di_a = sti_rd_a ? rom[sti_addr_a] : 16'hDEAD;
  assign sti_di_b = sti_rd_b ? rom[sti_addr_b] : 16'hDEAD;
  assign sti_di_c = sti_rd_c ? rom[sti_addr_c] : 16'hDEAD;

  dt_res_init dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
    .res_wr(res_wr_a), .res_addr(res_addr_a), .res_do(res_do_a));

  dt_res_init #(.FG_VAL(8'h01), .BG_VAL(8'h00), .BORDER_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
    .res_wr(res_wr_b), .res_addr(res_addr_b), .res_do(res_do_b));

  dt_res_init #(.FG_VAL(8'hFF), .BG_VAL(8'h10), .BORDER_ZERO(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .busy(busy_c), .done(done_c),
    .sti_rd(sti_rd_c), .sti_addr(sti_addr_c), .sti_di(sti_di_c),
    .res_wr(res_wr_c), .res_addr(res_addr_c), .res_do(res_do_c));

  logic [7:0] ram_a [0:16383];
  logic [7:0] ram_b [0:16383];
  logic [7:0] ram_c [0:16383];

  int total, bad;
  int cyc = 0;
  int wr_cnt, rd_cnt, rd_err, wr_err, done_cnt;
  int first_wr, last_wr, last_addr, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor and RAM models, sampled mid-cycle.
  always @(negedge clk) begin
    if (res_wr_a) begin
      ram_a[res_addr_a] = res_do_a;
      if (wr_cnt == 0) begin
        first_wr = cyc;
        if (res_addr_a != 14'd0) wr_err++;
      end else if (int'(res_addr_a) != last_addr + 1) wr_err++;
      last_addr = int'(res_addr_a);
      last_wr   = cyc;
      wr_cnt++;
    end
    if (res_wr_b) ram_b[res_addr_b] = res_do_b;
    if (res_wr_c) ram_c[res_addr_c] = res_do_c;
    if (sti_rd_a) begin
      if (int'(sti_addr_a) != rd_cnt) rd_err++;
      rd_cnt++;
    end
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    int         run;
    int         addr;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {busy_a, done_a, sti_rd_a, res_wr_a, sti_addr_a, res_addr_a, res_do_a}, 64'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; rd_err = 0; wr_err = 0; done_cnt = 0;
    first_wr = -1; last_wr = -1; last_addr = -1; done_cyc = -1;
  endtask

  function automatic logic [7:0] exp_px(input int a, input bit bz, input logic [7:0] fg, input logic [7:0] bg);
    int row, col;
    logic [15:0] wd;
    row = a / 128;
    col = a % 128;
    wd  = rom[a / 16];
    if (bz && (row == 0 || row == 127 || col == 0 || col == 127)) return bg;
    return wd[15 - (a % 16)] ? fg : bg;
  endfunction

  task automatic full_cmp(input string tag);
    int ea, eb, ec;
    ea = 0; eb = 0; ec = 0;
    for (int i = 0; i < 16384; i++) begin
      if (ram_a[i] !== exp_px(i, 1'b1, 8'h01, 8'h00)) ea++;
      if (ram_b[i] !== exp_px(i, 1'b0, 8'h01, 8'h00)) eb++;
      if (ram_c[i] !== exp_px(i, 1'b1, 8'hFF, 8'h10)) ec++;
    end
    chk({tag, "_img_a"}, ea, 0);
    chk({tag, "_img_b"}, eb, 0);
    chk({tag, "_img_c"}, ec, 0);
  endtask

  // One start pulse, full run, timing/protocol/image checks.
  task automatic do_run(input int r, input string tag);
    int s;
    clear_stats();
    tick();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17000 && done_cnt == 0; i++) tick();
    tick();
    tick();
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, s + 16386);
    chk({tag, "_first_wr"}, first_wr, s + 2);
    chk({tag, "_last_wr"}, last_wr, s + 16385);
    chk({tag, "_wr_cnt"}, wr_cnt, 16384);
    chk({tag, "_wr_nogap"}, last_wr - first_wr + 1, 16384);
    chk({tag, "_wr_seq"}, wr_err, 0);
    chk({tag, "_rd_cnt"}, rd_cnt, 1024);
    chk({tag, "_rd_seq"}, rd_err, 0);
    chk({tag, "_busy_end"}, busy_a, 0);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].run == r) begin
        chk($sformatf("%s_a_%0d", tag, vecs[i].addr), ram_a[vecs[i].addr], vecs[i].ea);
        chk($sformatf("%s_b_%0d", tag, vecs[i].addr), ram_b[vecs[i].addr], vecs[i].eb);
        chk($sformatf("%s_c_%0d", tag, vecs[i].addr), ram_c[vecs[i].addr], vecs[i].ec);
      end
    end
    full_cmp(tag);
  endtask

  initial begin
    int s, d, untouched;
    total = 0; bad = 0;
    reset = 1'b1;
    start = 1'b0;
    clear_stats();
    // run 1: all-ones ROM; run 2: word 0 = 8001, rest 0
    vecs[0] = '{1, 0,     8'h00, 8'h01, 8'h10};
    vecs[1] = '{1, 129,   8'h01, 8'h01, 8'hFF};
    vecs[2] = '{1, 16383, 8'h00, 8'h01, 8'h10};
    vecs[3] = '{1, 8256,  8'h01, 8'h01, 8'hFF};
    vecs[4] = '{1, 127,   8'h00, 8'h01, 8'h10};
    vecs[5] = '{2, 0,     8'h00, 8'h01, 8'h10};
    vecs[6] = '{2, 15,    8'h00, 8'h01, 8'h10};
    vecs[7] = '{2, 1,     8'h00, 8'h00, 8'h10};
    vecs[8] = '{2, 14,    8'h00, 8'h00, 8'h10};
    vecs[9] = '{2, 16,    8'h00, 8'h00, 8'h10};

    #2 reset = 1'b0;
    #1;
    chk_zero("reset_outputs");
    chk("reset_do_c", res_do_c, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_busy", busy_a, 0);
    chk("idle_rd", rd_cnt, 0);

    for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
    do_run(1, "ones");

    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    rom[0] = 16'h8001;
    do_run(2, "w8001");

    // start held high: one run, a second begins only from the next IDLE sample
    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    clear_stats();
    tick();
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < 17000 && done_cnt == 0; i++) tick();
    chk("held_done_cyc", done_cyc, s + 16386);
    full_cmp("held");
    d = done_cyc;
    clear_stats();
    for (int i = 0; i < 16384; i++) begin
      ram_a[i] = 8'h5A; ram_b[i] = 8'h5A; ram_c[i] = 8'h5A;
    end
    while (cyc < s + 20000) tick();
    chk("held_no_2nd_done", done_cnt, 0);
    chk("held_2nd_first_wr", first_wr, d + 3);
    start = 1'b0;

    // abort the second run after 5000 writes
    for (int i = 0; i < 5000 && wr_cnt < 5000; i++) tick();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk_zero("abort_outputs");
    chk("abort_do_c", res_do_c, 8'h00);
    repeat (3) tick();
    chk("abort_wr_cnt", wr_cnt, 5000);
    chk("abort_wr_seq", wr_err, 0);
    chk("abort_rd_cnt", rd_cnt, 313);
    chk("abort_rd_seq", rd_err, 0);
    chk("abort_last_px", ram_c[4999], exp_px(4999, 1'b1, 8'hFF, 8'h10));
    untouched = 0;
    for (int i = 5000; i < 16384; i++)
      if (ram_a[i] !== 8'h5A || ram_c[i] !== 8'h5A) untouched++;
    chk("abort_untouched", untouched, 0);

    reset = 1'b1;
    repeat (5) tick();
    chk("post_reset_idle", {busy_a, sti_rd_a, res_wr_a}, 0);
    do_run(3, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
